// File: rtl/freq_counter_pkg.sv
// Shared types and elaboration helpers for the gated frequency counter.
package freq_counter_pkg;

    typedef enum logic {
        s_SETTLE = 1'b0,
        s_GATE   = 1'b1
    } state_t;

    // Gate window length in CLK cycles.
    function automatic int gate_cycles_calc(input int clk_freq, input int gate_ms);
        return int'((longint'(clk_freq) / 64'sd1000) * longint'(gate_ms));
    endfunction

    function automatic bit gate_cycles_ok(input int gate_cycles);
        return gate_cycles >= 2;
    endfunction

    function automatic bit count_width_ok(input int count_width);
        return (count_width >= 2) && (count_width <= 32);
    endfunction

    function automatic bit sync_stages_ok(input int sync_stages);
        return (sync_stages >= 2) && (sync_stages <= 4);
    endfunction

endpackage

// File: rtl/freq_counter_sync.sv
// Multi-flop synchroniser for the measured signal with a registered rising-edge pulse.
module freq_counter_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic ASYNC_IN,
    output logic RISE
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rise_reg;

    // The stage before the last is what the last stage holds next cycle, so
    // rise_reg equals (last stage & ~its previous-cycle copy) as a flop output.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            sync_reg <= '0;
            rise_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], ASYNC_IN};
            rise_reg <= sync_reg[SYNC_STAGES-2] & ~sync_reg[SYNC_STAGES-1];
        end
    end

    assign RISE = rise_reg;

endmodule

// File: rtl/freq_counter.sv
// Counts synchronised rising edges of SIG_IN over a fixed gate window and
// publishes the saturated count once per window.
module freq_counter
    import freq_counter_pkg::*;
#(
    parameter int CLK_FREQ    = 100000000,
    parameter int GATE_MS     = 1000,
    parameter int COUNT_WIDTH = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   CLK,
    input  logic                   RESETN,
    input  logic                   SIG_IN,
    input  logic                   HOLD,
    output logic [COUNT_WIDTH-1:0] COUNT,
    output logic                   VALID,
    output logic                   OVERFLOW
);

    localparam int GATE_CYCLES = gate_cycles_calc(CLK_FREQ, GATE_MS);
    localparam int GATE_W      = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    localparam logic [GATE_W-1:0] GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
    localparam logic [2:0]        SETTLE_LAST = 3'(SYNC_STAGES);

    if (!gate_cycles_ok(GATE_CYCLES)) begin : g_bad_gate
        $error("freq_counter: gate window must span at least 2 CLK cycles");
    end
    if (!count_width_ok(COUNT_WIDTH)) begin : g_bad_width
        $error("freq_counter: COUNT_WIDTH must be 2..32");
    end
    if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync
        $error("freq_counter: SYNC_STAGES must be 2..4");
    end

    state_t                 state_reg, state_next;
    logic [2:0]             settle_reg, settle_next;
    logic [GATE_W-1:0]      gate_cnt_reg, gate_next;
    logic [COUNT_WIDTH-1:0] edge_cnt_reg, edge_next;
    logic                   sat_reg, sat_next;
    logic [COUNT_WIDTH-1:0] count_reg, count_next;
    logic                   valid_reg, valid_next;
    logic                   overflow_reg, overflow_next;

    logic                   rise;
    logic                   edge_at_max;
    logic [COUNT_WIDTH-1:0] edge_sum;
    logic                   sat_sum;

    freq_counter_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .ASYNC_IN(SIG_IN),
        .RISE    (rise)
    );

    // This cycle's edge folded into the running count, saturating at all-ones.
    assign edge_at_max = &edge_cnt_reg;
    assign edge_sum    = edge_cnt_reg + COUNT_WIDTH'(rise & ~edge_at_max);
    assign sat_sum     = sat_reg | (rise & edge_at_max);

    always_comb begin
        state_next    = state_reg;
        settle_next   = settle_reg;
        gate_next     = gate_cnt_reg;
        edge_next     = edge_cnt_reg;
        sat_next      = sat_reg;
        count_next    = count_reg;
        valid_next    = 1'b0;
        overflow_next = overflow_reg;
        case (state_reg)
            s_SETTLE: begin
                if (settle_reg == SETTLE_LAST) begin
                    state_next  = s_GATE;
                    settle_next = '0;
                    gate_next   = '0;
                    edge_next   = '0;
                    sat_next    = 1'b0;
                end else begin
                    settle_next = settle_reg + 3'd1;
                end
            end
            s_GATE: begin
                if (gate_cnt_reg == GATE_LAST) begin
                    if (!HOLD) begin
                        count_next    = edge_sum;
                        overflow_next = sat_sum;
                        valid_next    = 1'b1;
                    end
                    gate_next = '0;
                    edge_next = '0;
                    sat_next  = 1'b0;
                end else begin
                    gate_next = gate_cnt_reg + GATE_W'(1);
                    edge_next = edge_sum;
                    sat_next  = sat_sum;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_reg    <= s_SETTLE;
            settle_reg   <= '0;
            gate_cnt_reg <= '0;
            edge_cnt_reg <= '0;
            sat_reg      <= 1'b0;
            count_reg    <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            settle_reg   <= settle_next;
            gate_cnt_reg <= gate_next;
            edge_cnt_reg <= edge_next;
            sat_reg      <= sat_next;
            count_reg    <= count_next;
            valid_reg    <= valid_next;
            overflow_reg <= overflow_next;
        end
    end

    assign COUNT    = count_reg;
    assign VALID    = valid_reg;
    assign OVERFLOW = overflow_reg;

endmodule
